// File: rtl/range_pkg.sv
// -----------------------------------------------------------------------------
// range_pkg
// Shared definitions for the sample framer and its FIFO:
//   - state_e       : framer FSM state (IDLE, RUN, SINGLE)
//   - DEFAULT_WIDTH : default sample width in bits
//   - DEFAULT_DEPTH : default FIFO depth in entries (power of two, >= 2)
// -----------------------------------------------------------------------------
package range_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SINGLE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO with registered storage and an explicit occupancy counter.
// The head entry is presented combinationally from the storage array so the
// consumer can look at it and pop it in the same cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointers and occupancy to 0)
//   push   in   write wdata this cycle (ignored when full)
//   wdata  in   [W-1:0] entry to write
//   pop    in   discard the head entry this cycle (ignored when empty)
//   rdata  out  [W-1:0] head entry (undefined when empty)
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sample_framer.sv
// -----------------------------------------------------------------------------
// sample_framer
// Buffers {last, sample} pairs from a producer and replays them as framed
// samples for a downstream range finder: go marks the first sample of a frame,
// finish marks the cycle that closes it.
//
// Handshake: a sample is transferred on a rising edge where sample_valid and
// sample_ready are both high. sample_ready is the registered not-full flag of
// the FIFO and never depends on sample_valid; while sample_ready is low the
// producer keeps sample_in/sample_last stable and sample_valid asserted.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sample_in     in   [WIDTH-1:0] offered sample
//   sample_valid  in   sample_in/sample_last valid this cycle
//   sample_last   in   offered sample ends its frame
//   sample_ready  out  framer can accept a sample this cycle
//   data_out      out  [WIDTH-1:0] registered sample to the range finder
//   go            out  registered one-cycle frame-start strobe
//   finish        out  registered one-cycle frame-end strobe
//   busy          out  FSM is not IDLE
//   frame_count   out  [7:0] frames completed, modulo 256
// -----------------------------------------------------------------------------
module sample_framer
  import range_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             sample_last,
  output logic             sample_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic [7:0]       frame_count
);

  logic [WIDTH:0]   fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             head_last;
  logic [WIDTH-1:0] head_data;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             go_q;
  logic             finish_q;
  logic [7:0]       frame_count_q;

  sample_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sample_valid),
    .wdata ({sample_last, sample_in}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_last = fifo_rdata[WIDTH];
  assign head_data = fifo_rdata[WIDTH-1:0];

  // SINGLE spends one cycle emitting finish for a one-sample frame, so it
  // never consumes; IDLE and RUN consume whenever something is buffered.
  assign fifo_pop = !fifo_empty && (state_q != SINGLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      go_q          <= 1'b0;
      finish_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          finish_q <= 1'b0;
          if (!fifo_empty) begin
            data_q  <= head_data;
            go_q    <= 1'b1;
            state_q <= head_last ? SINGLE : RUN;
          end else begin
            data_q <= '0;
            go_q   <= 1'b0;
          end
        end
        RUN: begin
          go_q <= 1'b0;
          if (!fifo_empty) begin
            data_q   <= head_data;
            finish_q <= head_last;
            if (head_last) begin
              state_q       <= IDLE;
              frame_count_q <= frame_count_q + 8'd1;
            end
          end else begin
            // Bubble: repeating the last sample is harmless downstream.
            finish_q <= 1'b0;
          end
        end
        SINGLE: begin
          go_q          <= 1'b0;
          finish_q      <= 1'b1;
          frame_count_q <= frame_count_q + 8'd1;
          state_q       <= IDLE;
        end
        default: begin
          go_q     <= 1'b0;
          finish_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign sample_ready = !fifo_full;
  assign data_out     = data_q;
  assign go           = go_q;
  assign finish       = finish_q;
  assign busy         = (state_q != IDLE);
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_sample_framer.sv
// -----------------------------------------------------------------------------
// tb_sample_framer
// Self-checking bench for sample_framer. A behavioural model keeps the
// accepted samples in a queue and tracks whether a frame is open or a
// one-sample frame still owes its finish; outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_sample_framer;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         sample_last;
  logic         sample_ready;
  logic [W-1:0] data_out;
  logic         go;
  logic         finish;
  logic         busy;
  logic [7:0]   frame_count;

  sample_framer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_last  (sample_last),
    .sample_ready (sample_ready),
    .data_out     (data_out),
    .go           (go),
    .finish       (finish),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // exp_q holds accepted {last, data} entries not yet emitted.
  logic [W:0]   exp_q[$];
  logic         frame_open;    // first sample emitted, closing sample not yet
  logic         finish_owed;   // one-sample frame emitted, finish next cycle
  logic [W-1:0] m_data;
  logic         m_go;
  logic         m_fin;
  int           m_frames;
  logic         prev_go;
  logic         saw_full;

  task automatic model_reset();
    exp_q.delete();
    frame_open  = 1'b0;
    finish_owed = 1'b0;
    m_data      = '0;
    m_go        = 1'b0;
    m_fin       = 1'b0;
    m_frames    = 0;
    prev_go     = 1'b0;
  endtask

  // One rising edge: emit from the samples buffered before it, then accept.
  task automatic model_step(input logic accepted, input logic [W:0] entry);
    logic [W:0] h;
    if (finish_owed) begin
      m_go = 1'b0; m_fin = 1'b1; m_frames++; finish_owed = 1'b0;
    end else if (exp_q.size() == 0) begin
      m_go = 1'b0; m_fin = 1'b0;
      if (!frame_open) m_data = '0;
    end else begin
      h = exp_q.pop_front();
      m_data = h[W-1:0];
      if (!frame_open) begin
        m_go = 1'b1; m_fin = 1'b0;
        if (h[W]) finish_owed = 1'b1;
        else      frame_open  = 1'b1;
      end else begin
        m_go = 1'b0; m_fin = h[W];
        if (h[W]) begin frame_open = 1'b0; m_frames++; end
      end
    end
    if (accepted) exp_q.push_back(entry);
  endtask

  task automatic compare_outputs();
    check("data_out",     data_out,     m_data);
    check("go",           go,           m_go);
    check("finish",       finish,       m_fin);
    check("busy",         busy,         frame_open | finish_owed);
    check("frame_count",  frame_count,  m_frames % 256);
    check("sample_ready", sample_ready, exp_q.size() < D);
    check("go_fin_excl",  go & finish,  1'b0);
    check("go_consec",    go & prev_go, 1'b0);
    prev_go = go;
    if (!sample_ready) saw_full = 1'b1;
  endtask

  // ---------------------------------------------------------------- drivers
  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, output logic acc);
    compare_outputs();
    sample_valid = v;
    sample_in    = d;
    sample_last  = l;
    acc = v && (exp_q.size() < D);
    model_step(acc, {l, d});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic l);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, d, l, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    sample_in    = '0;
    sample_last  = 1'b0;
    rst_n        = 1'b0;
    #1;
    model_reset();
    check("rst_data_out",    data_out,     '0);
    check("rst_go",          go,           1'b0);
    check("rst_finish",      finish,       1'b0);
    check("rst_busy",        busy,         1'b0);
    check("rst_frame_count", frame_count,  '0);
    check("rst_ready",       sample_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic acc;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    sample_last  = 1'b0;
    saw_full     = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Four-sample frame back-to-back.
    send(8'd5, 1'b0); send(8'd9, 1'b0); send(8'd2, 1'b0); send(8'd7, 1'b1);
    idle(4);
    check("s4_frame_count", frame_count, 8'd1);

    // One-sample frame.
    do_reset();
    send(8'd42, 1'b1);
    idle(4);
    check("single_frame_count", frame_count, 8'd1);

    // Bubble in the middle of a frame.
    do_reset();
    send(8'd10, 1'b0);
    idle(3);
    send(8'd20, 1'b1);
    idle(4);
    check("bubble_frame_count", frame_count, 8'd1);

    // Two frames back-to-back.
    do_reset();
    send(8'd1, 1'b0); send(8'd2, 1'b1); send(8'd3, 1'b1);
    idle(5);
    check("two_frame_count", frame_count, 8'd2);

    // Continuous single-sample frames drain at half rate and fill the FIFO.
    do_reset();
    saw_full = 1'b0;
    for (int i = 0; i < 20; i++) send(8'(100 + i), 1'b1);
    check("fifo_filled", saw_full, 1'b1);
    idle(45);
    check("fill_frame_count", frame_count, 8'd20);

    // Reset in the middle of a four-sample frame.
    do_reset();
    send(8'd11, 1'b0); send(8'd12, 1'b0);
    idle(1);
    do_reset();
    idle(3);
    send(8'd13, 1'b0); send(8'd14, 1'b1);
    idle(4);
    check("after_rst_frame_count", frame_count, 8'd1);

    // Random traffic, long enough for frame_count to wrap.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 2) == 0, acc);
    end
    idle(2 * D + 4);
    check("random_drained", exp_q.size(), 0);

    // Random traffic with a reset landing mid-stream.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) == 0, acc);
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 4) == 0, acc);
    end
    idle(2 * D + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001: Parameter WIDTH, default 8, sample and data_out width in bits.
REQ-002: Parameter DEPTH, default 8, FIFO entries (power of two, min 2).
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low; the port is named rst_n.
REQ-005: sample_in  input  WIDTH  sample value offered by the producer.
REQ-006: sample_valid  input  1  sample_in and sample_last are valid this cycle.
REQ-007: sample_last  input  1  the offered sample ends its frame.
REQ-008: sample_ready  output  1  framer can accept a sample this cycle.
REQ-009: data_out  output  WIDTH  registered sample to the downstream range finder.
REQ-010: go  output  1  registered one-cycle frame-start strobe.
REQ-011: finish  output  1  registered one-cycle frame-end strobe.
REQ-012: busy  output  1  high while the state is not IDLE.
REQ-013: frame_count  output  8  number of frames completed, modulo 256.

Function
REQ-014: A handshake occurs when sample_valid and sample_ready are both high at a rising edge; {sample_last, sample_in} is then written to the FIFO.
REQ-015: sample_ready shall equal not-full, with no combinational path from sample_valid or any downstream signal.
REQ-016: When full, sample_ready=0; the producer holds its sample and nothing is dropped.
REQ-017: A push and a pop in the same cycle on a non-empty FIFO shall both take effect, leaving the occupancy unchanged.
REQ-018: The FSM has three states, IDLE, RUN and SINGLE; data_out, go and finish are registered outputs of its transitions.
REQ-019: In IDLE with the FIFO empty: data_out<=0, go<=0, finish<=0, and the state stays IDLE.
REQ-020: In IDLE with the FIFO non-empty: pop the head; data_out<=head.data, go<=1, finish<=0.
- Next state is SINGLE if head.last is set, else RUN.
REQ-021: In RUN with the FIFO non-empty: pop the head; data_out<=head.data, go<=0, finish<=head.last.
- If head.last is set, the next state is IDLE and frame_count increments.
REQ-022: In RUN with the FIFO empty (bubble): data_out holds its previous value, go<=0, finish<=0, the state stays RUN.
- Repeating a sample leaves the downstream min/max unchanged.
REQ-023: In SINGLE: data_out holds its value, finish<=1, go<=0, frame_count increments, the next state is IDLE.
- go and finish are therefore never high in the same cycle.
REQ-024: go shall be high for exactly one cycle per frame and never in two consecutive cycles.
- finish shall be high for exactly one cycle per frame.
REQ-025: A new frame's go may occur in the cycle immediately after the previous frame's finish.
REQ-026: Latency: a sample accepted at edge k whose FIFO is empty and whose FSM is ready appears on data_out after edge k+1.
REQ-027: frame_count wraps from 255 to 0 without any flag.

Reset
REQ-028: While rst_n=0: FSM=IDLE, FIFO pointers and occupancy=0.
- data_out=0, go=0, finish=0, busy=0, frame_count=0.
REQ-029: Reset asserted mid-frame shall discard the partial frame and all buffered samples, with no finish emitted.
- sample_ready=1 from the first edge after rst_n deasserts.

Structure
REQ-030: A shared package range_pkg shall hold the state enum type (IDLE, RUN, SINGLE) and the default WIDTH/DEPTH constants.
REQ-031: The FIFO shall be a sub-module sample_fifo (WIDTH+1 bits wide, DEPTH deep, full/empty flags, registered storage).
- The FSM lives in sample_framer.

Verification
REQ-032: Push 5,9,2,7(last) back-to-back from reset -> data_out 5,9,2,7 on consecutive cycles; go with 5, finish with 7, frame_count=1.
REQ-033: Push single sample 42(last) -> data_out=42 for two cycles, go in the first, finish in the second, never together; frame_count=1.
REQ-034: Push 10, then 3 idle cycles, then 20(last) -> data_out holds 10 during the bubble, go=finish=0 there; finish with 20.
REQ-035: Hold sample_valid=1 with 12 samples while downstream drains -> sample_ready drops after 8 buffered, every sample is emitted in order, none is lost.
REQ-036: Two frames 1,2(last) and 3(last) back-to-back -> finish(2) immediately followed by go(3); frame_count=2.
REQ-037: Assert rst_n=0 after 2 samples of a 4-sample frame -> all outputs 0, no finish; a subsequent frame runs normally from count 0.
